// File: rtl/mon_prod_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: FSM encoding,
// counter width and the default operand width.
package mon_prod_pkg;

  localparam int unsigned DEFAULT_BIT_LEN = 1024;
  localparam int unsigned COUNT_W         = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mon_prod_step.sv
// One radix-2 Montgomery iteration: optionally add B, add M if the sum is odd,
// then halve. Purely combinational.
module mon_prod_step
  import mon_prod_pkg::*;
#(
  parameter int unsigned bitLen = DEFAULT_BIT_LEN
) (
  input  logic [bitLen+1:0] acc,
  input  logic              a_bit,
  input  logic [bitLen-1:0] b,
  input  logic [bitLen-1:0] m,
  output logic [bitLen+1:0] acc_next
);

  logic [bitLen+1:0] sum_b;
  logic [bitLen+1:0] sum_m;

  // Two guard bits keep acc + B + M (< 4M) from overflowing.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each line sees the value
    // computed on the line above, exactly like the arithmetic it describes.
    sum_b    = a_bit ? acc + {2'b00, b} : acc;
    sum_m    = sum_b[0] ? sum_b + {2'b00, m} : sum_b;
    acc_next = sum_m >> 1;
  end

endmodule

// File: rtl/mon_prod.sv
// Bit-serial Montgomery product P = A*B*2^(-n) mod M: operand latch, iteration
// counter, FSM and the final conditional subtraction.
module mon_prod
  import mon_prod_pkg::*;
#(
  parameter int unsigned bitLen = DEFAULT_BIT_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [bitLen-1:0]  A,
  input  logic [bitLen-1:0]  B,
  input  logic [bitLen-1:0]  M,
  input  logic [COUNT_W-1:0] mp_count,
  output logic               stop,
  output logic [bitLen:0]    P
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t state;
  state_t state_next;

  logic [bitLen-1:0]  a_reg;
  logic [bitLen-1:0]  b_reg;
  logic [bitLen-1:0]  m_reg;
  logic [COUNT_W-1:0] n_reg;
  logic [COUNT_W-1:0] cnt;
  logic [bitLen+1:0]  acc;
  logic [bitLen+1:0]  acc_step;
  logic [bitLen+1:0]  acc_sub;
  logic               acc_ge_m;
  logic               last_iter;

  mon_prod_step #(
    .bitLen(bitLen)
  ) u_step (
    .acc      (acc),
    .a_bit    (a_reg[0]),
    .b        (b_reg),
    .m        (m_reg),
    .acc_next (acc_step)
  );

  assign last_iter = (cnt == n_reg - CNT_ONE);
  assign acc_ge_m  = (acc >= {2'b00, m_reg});
  assign acc_sub   = acc - {2'b00, m_reg};
  assign P         = acc[bitLen:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: state_next gets a default before the case, so every path assigns
    // it and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (mp_count == '0) ? SUB : CALC;
      CALC:    if (last_iter) state_next = SUB;
      SUB:     state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The multiplier is consumed LSB first by shifting it right each iteration;
  // bits past bitLen therefore read as zero without any index compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking '<='; the operand registers
      // are reset too, since aborted operands must not survive a reset.
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      n_reg <= '0;
      cnt   <= '0;
      acc   <= '0;
      stop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            m_reg <= M;
            n_reg <= mp_count;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        CALC: begin
          acc   <= acc_step;
          a_reg <= a_reg >> 1;
          cnt   <= cnt + CNT_ONE;
        end
        SUB: begin
          if (acc_ge_m) acc <= acc_sub;
          stop <= 1'b1;
        end
        DONE: begin
          if (!start) stop <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_prod.sv
// Self-checking bench for mon_prod: directed vectors, reset/abort and
// handshake sequences, and random operands against a modular-arithmetic model.
module tb_mon_prod;

  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BL-1:0] A, B, M;
  logic [9:0]    mp_count;
  logic          stop;
  logic [BL:0]   P;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mon_prod #(.bitLen(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .M        (M),
    .mp_count (mp_count),
    .stop     (stop),
    .P        (P)
  );

  typedef struct {
    longint a;
    longint b;
    longint m;
    int     n;
    longint p;
    int     hold;
    string  name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A*B*2^(-n) mod M, using the modular inverse of 2, which is (M+1)/2 for odd M.
  function automatic longint ref_mont(input longint a, input longint b, input longint m, input int n);
    longint inv2 = (m + 1) / 2;
    longint r    = (a * b) % m;
    for (int i = 0; i < n; i++) r = (r * inv2) % m;
    return r;
  endfunction

  // Start one product with start held high, count edges (the sampling edge is
  // edge 1) until stop, check the result, hold start, then release it.
  task automatic run_op(input longint a, input longint b, input longint m, input int n,
                        input longint exp_p, input int hold, input string name);
    int edges;
    A = BL'(a); B = BL'(b); M = BL'(m); mp_count = 10'(n); start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    A = BL'($urandom); B = BL'($urandom); M = BL'($urandom); mp_count = 10'($urandom);
    while (!stop && edges < n + 8) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, " latency"}, 64'(edges), 64'(n + 2));
    check({name, " stop"}, 64'(stop), 64'd1);
    check({name, " P"}, 64'(P), 64'(exp_p));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold stop"}, 64'(stop), 64'd1);
      check({name, " hold P"}, 64'(P), 64'(exp_p));
    end
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " stop fall"}, 64'(stop), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{a: 571, b: 435, m: 589, n: 10, p: 571, hold: 3, name: "vec571"};
    vecs[1] = '{a: 216, b: 123, m: 589, n: 10, p: 187, hold: 0, name: "vec216"};
    vecs[2] = '{a: 1,   b: 1,   m: 589, n: 10, p: 218, hold: 1, name: "inv1024"};
    vecs[3] = '{a: 100, b: 200, m: 589, n: 0,  p: 0,   hold: 1, name: "n_zero"};
    vecs[4] = '{a: 588, b: 588, m: 589, n: 10, p: 218, hold: 0, name: "max_ops"};
    vecs[5] = '{a: 0,   b: 300, m: 589, n: 10, p: 0,   hold: 0, name: "a_zero"};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; M = '0; mp_count = '0;
    #12;
    check("reset stop", 64'(stop), 64'd0);
    check("reset P", 64'(P), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle stop", 64'(stop), 64'd0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].n, vecs[i].p, vecs[i].hold, vecs[i].name);

    // Abort after five iterations; the block must clear at once and wait for start.
    A = BL'(571); B = BL'(435); M = BL'(589); mp_count = 10'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort stop", 64'(stop), 64'd0);
    check("abort P", 64'(P), 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      check("post-abort idle stop", 64'(stop), 64'd0);
    end
    check("post-abort idle P", 64'(P), 64'd0);
    run_op(571, 435, 589, 10, 571, 2, "after_abort");

    // Random operands with odd M < 2^n; n above BL exercises zero upper A bits.
    for (int k = 0; k < 40; k++) begin
      int n, mmax, m, a, b;
      n    = $urandom_range(20, 2);
      mmax = (n >= BL) ? (1 << BL) - 1 : (1 << n) - 1;
      m    = $urandom_range(mmax, 3) | 1;
      a    = $urandom_range(m - 1, 0);
      b    = $urandom_range(m - 1, 0);
      run_op(a, b, m, n, ref_mont(a, b, m, n), k % 3, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
